i2c_sht_target: RTL and testbench

Open-drain I2C target (responder) that emulates an SHT40-style sensor on the same SCL/SDA bus driven by our I2C master. It oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, and ACKs and presents written command bytes to a local host. On reads it shifts out a host-loaded 6-byte response. It serves as a bus-functional partner for the master and as a synthesizable sensor stand-in for board bring-up.

---
 rtl/i2c_sht_target_if.sv | 23 ++
 rtl/i2c_sht_target.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_sht_target.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_sht_target_if.sv
// Host-side handshake between the SHT-style I2C target and its local controller.
interface i2c_sht_target_if;
  logic [47:0] resp_data;
  logic        resp_load;
  logic        resp_ready;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        busy;
  logic [3:0]  bytes_sent;
  logic [2:0]  state_out;

  // The host loads responses and consumes commands.
  modport master (
    output resp_data, resp_load,
    input  resp_ready, cmd_data, cmd_valid, busy, bytes_sent, state_out
  );

  // The target serves responses and reports commands.
  modport slave (
    input  resp_data, resp_load,
    output resp_ready, cmd_data, cmd_valid, busy, bytes_sent, state_out
  );
endinterface

// File: rtl/i2c_sht_target.sv
// Open-drain I2C target emulating an SHT40-style sensor.
// Optional feature: define I2C_TARGET_CRC_EN to replace buffer bytes 2 and 5
// with Sensirion CRC-8 over bytes {0,1} and {3,4}.
module i2c_sht_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h44,
  parameter int unsigned RESP_BYTES  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl,
  inout  wire              sda,
  i2c_sht_target_if.slave  host
);
  localparam int unsigned BUF_W = RESP_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, RX = 3'd3,
    RX_ACK = 3'd4, TX = 3'd5, TX_ACK = 3'd6, WAIT_STOP = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             rw_q, rw_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic [3:0]       bytes_sent_q, bytes_sent_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       cmd_data_q, cmd_data_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             busy_q, busy_d;
  logic             resp_ready_q, resp_ready_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] tx_buf_c;
  logic [7:0]       resp_byte_c;
  logic             scl_rise_c, scl_fall_c, start_c, stop_c, sda_s_c;

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign host.resp_ready = resp_ready_q;
  assign host.cmd_data   = cmd_data_q;
  assign host.cmd_valid  = cmd_valid_q;
  assign host.busy       = busy_q;
  assign host.bytes_sent = bytes_sent_q;
  assign host.state_out  = state_q;

`ifdef I2C_TARGET_CRC_EN
  // Sensirion CRC-8: poly 0x31, init 0xFF, MSB first, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else             c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign tx_buf_c = {buf_q[47:32], crc8(buf_q[47:32]), buf_q[23:8], crc8(buf_q[23:8])};
`else
  assign tx_buf_c = buf_q;
`endif

  // Synchronizer taps: [1] is the synced value, [2] the previous one for edges.
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl};
    sda_sync_d = {sda_sync_q[1:0], sda};
    sda_s_c    = sda_sync_q[1];
    scl_rise_c = scl_sync_q[1] & ~scl_sync_q[2];
    scl_fall_c = ~scl_sync_q[1] & scl_sync_q[2];
    start_c    = scl_sync_q[1] & ~sda_sync_q[1] & sda_sync_q[2];
    stop_c     = scl_sync_q[1] & sda_sync_q[1] & ~sda_sync_q[2];
  end

  // Select the response byte for the current index, padding with 0xFF.
  always_comb begin
    resp_byte_c = 8'hFF;
    for (int unsigned i = 0; i < RESP_BYTES; i++) begin
      if (byte_idx_q == 4'(i)) resp_byte_c = tx_buf_c[BUF_W-1-8*i -: 8];
    end
  end

  // Next-state and output logic; STOP beats START beats per-state actions.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_sh_d      = tx_sh_q;
    rw_d         = rw_q;
    byte_idx_d   = byte_idx_q;
    bytes_sent_d = bytes_sent_q;
    sda_oe_d     = sda_oe_q;
    cmd_data_d   = cmd_data_q;
    cmd_valid_d  = 1'b0;
    busy_d       = busy_q;
    buf_d        = buf_q;

    if (host.resp_load && (resp_ready_q || stop_c)) buf_d = host.resp_data;

    if (stop_c) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      bit_cnt_d = 4'd0;
    end else if (start_c) begin
      state_d   = ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise_c) begin
          shift_d   = {shift_q[5:0], sda_s_c};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            if (shift_q == TARGET_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_s_c;
              if (sda_s_c) begin
                byte_idx_d   = 4'd0;
                bytes_sent_d = 4'd0;
              end
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end
        // First falling edge pulls SDA low, the next one releases it.
        ADDR_ACK, RX_ACK: if (scl_fall_c) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw_q) begin
            state_d   = TX;
            sda_oe_d  = ~resp_byte_c[7];
            tx_sh_d   = {resp_byte_c[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else begin
            state_d   = RX;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end
        RX: if (scl_rise_c) begin
          shift_d   = {shift_q[5:0], sda_s_c};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            cmd_data_d  = {shift_q, sda_s_c};
            cmd_valid_d = 1'b1;
            state_d     = RX_ACK;
          end
        end
        // bit_cnt 0 means a fresh byte must be loaded on this falling edge.
        TX: if (scl_fall_c) begin
          if (bit_cnt_q == 4'd0) begin
            sda_oe_d  = ~resp_byte_c[7];
            tx_sh_d   = {resp_byte_c[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end else if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = TX_ACK;
          end else begin
            sda_oe_d  = ~tx_sh_q[7];
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        TX_ACK: if (scl_rise_c) begin
          if (!sda_s_c) begin
            bytes_sent_d = (bytes_sent_q == 4'hF) ? bytes_sent_q : bytes_sent_q + 4'd1;
            byte_idx_d   = (byte_idx_q == 4'hF) ? byte_idx_q : byte_idx_q + 4'd1;
            bit_cnt_d    = 4'd0;
            state_d      = TX;
          end else begin
            state_d = WAIT_STOP;
            busy_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    resp_ready_d = !(state_d == TX || state_d == TX_ACK);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      scl_sync_q   <= 3'b111;
      sda_sync_q   <= 3'b111;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      tx_sh_q      <= 8'd0;
      rw_q         <= 1'b0;
      byte_idx_q   <= 4'd0;
      bytes_sent_q <= 4'd0;
      sda_oe_q     <= 1'b0;
      cmd_data_q   <= 8'd0;
      cmd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_ready_q <= 1'b1;
      buf_q        <= '0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_sh_q      <= tx_sh_d;
      rw_q         <= rw_d;
      byte_idx_q   <= byte_idx_d;
      bytes_sent_q <= bytes_sent_d;
      sda_oe_q     <= sda_oe_d;
      cmd_data_q   <= cmd_data_d;
      cmd_valid_q  <= cmd_valid_d;
      busy_q       <= busy_d;
      resp_ready_q <= resp_ready_d;
      buf_q        <= buf_d;
    end
  end
endmodule

// File: tb/tb_i2c_sht_target.sv
// Directed bench for i2c_sht_target: bit-banged I2C master, hand-computed expectations.
module tb_i2c_sht_target;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda_w;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cv_cnt = 0;
  int   cv_base;
  logic ack;
  logic [7:0] rb;
  logic [7:0] exp_rd [8];
  logic [47:0] load_val;
  int   n_rd;
  logic [3:0] exp_sent;

  i2c_sht_target_if hif ();

  pullup (sda_w);
  assign sda_w = m_sda_low ? 1'b0 : 1'bz;

  i2c_sht_target dut (
    .clk   (clk),
    .rst_n (rst_n),
    .scl   (scl),
    .sda   (sda_w),
    .host  (hif)
  );

  always #5 clk = ~clk;

  // Count cmd_valid pulses so bursts can be measured as deltas.
  always @(posedge clk) if (hif.cmd_valid) cv_cnt <= cv_cnt + 1;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wclk(5);
    scl = 1'b1;       wclk(5);
    m_sda_low = 1'b1; wclk(5);
    scl = 1'b0;       wclk(5);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wclk(5);
    scl = 1'b1;       wclk(5);
    m_sda_low = 1'b0; wclk(5);
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; wclk(5);
    scl = 1'b1;     wclk(10);
    scl = 1'b0;     wclk(5);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_sda_low = 1'b0; wclk(5);
    scl = 1'b1;       wclk(5);
    a = sda_w;        wclk(5);
    scl = 1'b0;       wclk(5);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_sda_low = 1'b0; wclk(5);
      scl = 1'b1;       wclk(5);
      b = {b[6:0], sda_w}; wclk(5);
      scl = 1'b0;
    end
    wclk(5);
    m_sda_low = master_ack; wclk(5);
    scl = 1'b1;             wclk(10);
    scl = 1'b0;             wclk(5);
    m_sda_low = 1'b0;
  endtask

  task automatic load_resp(input logic [47:0] d);
    hif.resp_data = d;
    hif.resp_load = 1'b1;
    wclk(1);
    hif.resp_load = 1'b0;
  endtask

  initial begin
    hif.resp_data = 48'h0;
    hif.resp_load = 1'b0;
`ifdef I2C_TARGET_CRC_EN
    load_val = 48'hBEEF_00_1234_00;
    exp_rd = '{8'hBE, 8'hEF, 8'h92, 8'h12, 8'h34, 8'h37, 8'hFF, 8'hFF};
    n_rd = 6;
    exp_sent = 4'd5;
`else
    load_val = 48'h0102_0304_0506;
    exp_rd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'hFF};
    n_rd = 8;
    exp_sent = 4'd7;
`endif
    wclk(3);
    rst_n = 1'b1;
    wclk(3);

    // Reset state
    check("rst_state", 48'(hif.state_out), 48'd0);
    check("rst_busy", 48'(hif.busy), 48'd0);
    check("rst_ready", 48'(hif.resp_ready), 48'd1);
    check("rst_cvalid", 48'(hif.cmd_valid), 48'd0);
    check("rst_cdata", 48'(hif.cmd_data), 48'd0);
    check("rst_sent", 48'(hif.bytes_sent), 48'd0);
    check("rst_sda", 48'(sda_w), 48'd1);

    // Write 0x88 to 0x44
    cv_base = cv_cnt;
    i2c_start();
    write_byte(8'h88, ack);
    check("wr_addr_ack", 48'(ack), 48'd0);
    check("wr_busy", 48'(hif.busy), 48'd1);
    write_byte(8'h88, ack);
    check("wr_data_ack", 48'(ack), 48'd0);
    check("wr_cdata", 48'(hif.cmd_data), 48'h88);
    check("wr_cv_pulses", 48'(cv_cnt - cv_base), 48'd1);
    i2c_stop();
    wclk(5);
    check("wr_busy_stop", 48'(hif.busy), 48'd0);
    check("wr_state_stop", 48'(hif.state_out), 48'd0);

    // Write to wrong address 0x45
    cv_base = cv_cnt;
    i2c_start();
    write_byte(8'h8A, ack);
    check("na_ack", 48'(ack), 48'd1);
    check("na_state", 48'(hif.state_out), 48'd7);
    write_byte(8'h11, ack);
    check("na_data_ack", 48'(ack), 48'd1);
    check("na_state2", 48'(hif.state_out), 48'd7);
    check("na_cv", 48'(cv_cnt - cv_base), 48'd0);
    i2c_stop();
    wclk(5);
    check("na_state_stop", 48'(hif.state_out), 48'd0);

    // Read response buffer, ACK all but the last byte
    load_resp(load_val);
    wclk(2);
    i2c_start();
    write_byte(8'h89, ack);
    check("rd_addr_ack", 48'(ack), 48'd0);
    check("rd_ready_tx", 48'(hif.resp_ready), 48'd0);
    for (int i = 0; i < n_rd; i++) begin
      read_byte(i < n_rd - 1, rb);
      check($sformatf("rd_byte%0d", i), 48'(rb), 48'(exp_rd[i]));
    end
    check("rd_sent", 48'(hif.bytes_sent), 48'(exp_sent));
    check("rd_sda_rel", 48'(sda_w), 48'd1);
    check("rd_state_nack", 48'(hif.state_out), 48'd7);
    check("rd_busy_nack", 48'(hif.busy), 48'd0);
    check("rd_ready_nack", 48'(hif.resp_ready), 48'd1);
    i2c_stop();
    wclk(5);

    // Write 0xFD, repeated START, read; a load during TX is ignored
    cv_base = cv_cnt;
    i2c_start();
    write_byte(8'h88, ack);
    check("rs_addr_ack", 48'(ack), 48'd0);
    write_byte(8'hFD, ack);
    check("rs_data_ack", 48'(ack), 48'd0);
    check("rs_cdata", 48'(hif.cmd_data), 48'hFD);
    check("rs_cv", 48'(cv_cnt - cv_base), 48'd1);
    i2c_start();
    write_byte(8'h89, ack);
    check("rs_raddr_ack", 48'(ack), 48'd0);
    check("rs_state_tx", 48'(hif.state_out), 48'd5);
    check("rs_ready_tx", 48'(hif.resp_ready), 48'd0);
    check("rs_busy", 48'(hif.busy), 48'd1);
    load_resp(48'hA5A5_A5A5_A5A5);
    read_byte(1'b1, rb);
    check("rs_byte0", 48'(rb), 48'(exp_rd[0]));
    read_byte(1'b0, rb);
    check("rs_byte1", 48'(rb), 48'(exp_rd[1]));
    check("rs_sent", 48'(hif.bytes_sent), 48'd1);
    i2c_stop();
    wclk(5);
    check("rs_ready_idle", 48'(hif.resp_ready), 48'd1);
    check("rs_state_idle", 48'(hif.state_out), 48'd0);

    // Reset during ADDR_ACK while the target holds SDA low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(load_val[0] | ((8'h88 >> i) & 8'h01) == 8'h01 ? 1'b1 : 1'b0);
    m_sda_low = 1'b0;
    wclk(1);
    check("ra_sda_low", 48'(sda_w), 48'd0);
    check("ra_state", 48'(hif.state_out), 48'd2);
    rst_n = 1'b0;
    wclk(1);
    rst_n = 1'b1;
    wclk(2);
    check("ra_sda_rel", 48'(sda_w), 48'd1);
    check("ra_state_rst", 48'(hif.state_out), 48'd0);
    check("ra_busy_rst", 48'(hif.busy), 48'd0);
    check("ra_ready_rst", 48'(hif.resp_ready), 48'd1);
    wclk(5);
    scl = 1'b1;
    wclk(10);
    i2c_start();
    write_byte(8'h88, ack);
    check("ra_next_ack", 48'(ack), 48'd0);
    write_byte(8'h42, ack);
    check("ra_next_dack", 48'(ack), 48'd0);
    check("ra_next_cdata", 48'(hif.cmd_data), 48'h42);
    i2c_stop();
    wclk(5);
    check("ra_next_busy", 48'(hif.busy), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
